// File: rtl/imm_extend_pipe.sv
// Immediate-extension stage between decode and execute: combinational extend,
// one result register plus a skid register so in_ready comes straight from a flop.
module imm_extend_pipe #(
  parameter int DATA_W = 32,
  parameter int TAG_W  = 4,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [23:0]       instr,
  input  logic [2:0]        imm_src,
  input  logic [TAG_W-1:0]  in_tag,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] ext_imm,
  output logic [TAG_W-1:0]  out_tag,
  output logic              illegal,
  output logic [CNT_W-1:0]  illegal_cnt
);

  function automatic logic [DATA_W-1:0] extend_imm(input logic [23:0] ins,
                                                   input logic [2:0]  src);
    logic [63:0]              w_sh;
    logic signed [7:0]        w_s8;
    logic signed [11:0]       w_s12;
    logic signed [25:0]       w_s26;
    logic signed [DATA_W-1:0] w_res;
    // Doubling the word turns the rotate into a plain right shift.
    w_sh  = {2{24'h000000, ins[7:0]}} >> {ins[11:8], 1'b0};
    w_s8  = signed'(ins[7:0]);
    w_s12 = signed'(ins[11:0]);
    w_s26 = signed'({ins[23:0], 2'b00});
    case (src)
      3'b000:  w_res = DATA_W'(w_sh[31:0]);
      3'b001:  w_res = DATA_W'(w_s8);
      3'b010:  w_res = DATA_W'(ins[11:0]);
      3'b011:  w_res = DATA_W'(w_s12);
      3'b100:  w_res = DATA_W'(w_s26);
      3'b101:  w_res = DATA_W'({ins[11:8], ins[3:0]});
      default: w_res = '0;
    endcase
    return w_res;
  endfunction

  function automatic logic is_reserved(input logic [2:0] src);
    return src[2] & src[1];
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] cnt);
    return (cnt == '1) ? cnt : cnt + 1'b1;
  endfunction

  logic [DATA_W-1:0] w_imm_p0;
  logic              w_ill_p0;
  logic              w_acc_p0;
  logic              w_take_p1;
  logic              w_skid_full;
  logic              w_main_ld;
  logic              w_skid_ld;
  logic [DATA_W-1:0] w_nxt_imm;
  logic [TAG_W-1:0]  w_nxt_tag;
  logic              w_nxt_ill;

  logic              r_vld_p1;
  logic              r_in_ready;
  logic [DATA_W-1:0] r_imm_p1;
  logic [TAG_W-1:0]  r_tag_p1;
  logic              r_ill_p1;
  logic [CNT_W-1:0]  r_cnt;
  logic [DATA_W-1:0] r_sk_imm;
  logic [TAG_W-1:0]  r_sk_tag;
  logic              r_sk_ill;

  // Stage p0: combinational extension of the incoming field
  assign w_imm_p0    = extend_imm(instr, imm_src);
  assign w_ill_p0    = is_reserved(imm_src);
  assign w_acc_p0    = in_valid && r_in_ready;
  assign w_skid_full = !r_in_ready;
  assign w_take_p1   = !r_vld_p1 || out_ready;
  assign w_main_ld   = !flush && w_take_p1 && (w_skid_full || w_acc_p0);
  assign w_skid_ld   = !flush && !w_take_p1 && w_acc_p0;
  assign w_nxt_imm   = w_skid_full ? r_sk_imm : w_imm_p0;
  assign w_nxt_tag   = w_skid_full ? r_sk_tag : in_tag;
  assign w_nxt_ill   = w_skid_full ? r_sk_ill : w_ill_p0;

  // Stage p1: main register drives the outputs, skid catches the stalled accept
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_vld_p1   <= 1'b0;
      r_in_ready <= 1'b1;
      r_imm_p1   <= '0;
      r_tag_p1   <= '0;
      r_ill_p1   <= 1'b0;
      r_cnt      <= '0;
    end else begin
      if (flush) begin
        r_vld_p1   <= 1'b0;
        r_in_ready <= 1'b1;
      end else if (w_take_p1) begin
        r_vld_p1   <= w_skid_full || w_acc_p0;
        r_in_ready <= 1'b1;
      end else if (w_acc_p0) begin
        r_in_ready <= 1'b0;
      end
      if (w_main_ld) begin
        r_imm_p1 <= w_nxt_imm;
        r_tag_p1 <= w_nxt_tag;
        r_ill_p1 <= w_nxt_ill;
      end
      if (w_acc_p0 && !flush && w_ill_p0)
        r_cnt <= sat_inc(r_cnt);
    end
  end

  always_ff @(posedge clk) begin
    if (w_skid_ld) begin
      r_sk_imm <= w_imm_p0;
      r_sk_tag <= in_tag;
      r_sk_ill <= w_ill_p0;
    end
  end

  assign in_ready    = r_in_ready;
  assign out_valid   = r_vld_p1;
  assign ext_imm     = r_imm_p1;
  assign out_tag     = r_tag_p1;
  assign illegal     = r_ill_p1;
  assign illegal_cnt = r_cnt;

endmodule
